// File: rtl/ci_pkg.sv
// Shared types for the custom-instruction initiator.
// Provides FSM state encoding and default data width.
package ci_pkg;

  localparam int CI_DATA_W = 32;

  typedef enum logic [2:0] {
    CI_IDLE,
    CI_START,
    CI_WAIT,
    CI_RESP,
    CI_ABORT
  } ci_state_t;

endpackage

// File: rtl/ci_watchdog.sv
// Clearable enabled counter with terminal-count flag.
// Ports: clk, reset, clr, en in; tc out (count == TIMEOUT_CYCLES-1).
module ci_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt_q <= '0;
    else if (en)
      cnt_q <= cnt_q + 1'b1;
  end

  assign tc = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ci_initiator.sv
// Valid/ready front end driving a multi-cycle CI slave, with watchdog abort.
// Ports: req_*/rsp_* handshakes, hold stall, ci_* slave side, busy status.
module ci_initiator
  import ci_pkg::*;
#(
  parameter int DATA_W         = CI_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              ci_clk_en,
  output logic              ci_reset,
  output logic              ci_start,
  output logic [DATA_W-1:0] ci_dataa,
  output logic [DATA_W-1:0] ci_datab,
  input  logic              ci_done,
  input  logic [DATA_W-1:0] ci_result
);

  ci_state_t state_q, state_d;
  logic abort_q;
  logic ld_req, ld_rsp;
  logic wd_clr, wd_en, wd_tc;

  ci_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk  (clk),
    .reset(reset),
    .clr  (wd_clr),
    .en   (wd_en),
    .tc   (wd_tc)
  );

  assign ci_clk_en = ~hold;
  assign ci_reset  = reset | abort_q;
  assign busy      = (state_q != CI_IDLE);

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ci_start  = 1'b0;
    ld_req    = 1'b0;
    ld_rsp    = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    unique case (state_q)
      CI_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          ld_req  = 1'b1;
          state_d = CI_START;
        end
      end
      CI_START: begin
        // Start stays high across hold; the slave
        // ignores it while its clk_en is low.
        ci_start = 1'b1;
        if (!hold) begin
          wd_clr  = 1'b1;
          state_d = CI_WAIT;
        end
      end
      CI_WAIT: begin
        // Done is only meaningful on enabled cycles;
        // done wins over a coincident terminal count.
        if (!hold) begin
          if (ci_done) begin
            ld_rsp  = 1'b1;
            state_d = CI_RESP;
          end else if (wd_tc) begin
            state_d = CI_ABORT;
          end else begin
            wd_en = 1'b1;
          end
        end
      end
      CI_ABORT: state_d = CI_RESP;
      CI_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_d = CI_IDLE;
      end
      default: state_d = CI_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CI_IDLE;
      abort_q     <= 1'b0;
      rsp_result  <= '0;
      rsp_timeout <= 1'b0;
      ci_dataa    <= '0;
      ci_datab    <= '0;
    end else begin
      state_q <= state_d;
      abort_q <= (state_d == CI_ABORT);
      if (ld_req) begin
        ci_dataa <= req_a;
        ci_datab <= req_b;
      end
      if (ld_rsp) begin
        rsp_result  <= ci_result;
        rsp_timeout <= 1'b0;
      end else if (state_q == CI_ABORT) begin
        rsp_result  <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ci_initiator.sv
// Directed bench for ci_initiator with a behavioural GCD slave.
// Covers latency, hold, timeout, backpressure and reset.
module tb_ci_initiator;
  import ci_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset, hold, req_valid, req_ready;
  logic [W-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [W-1:0] rsp_result;
  logic ci_clk_en, ci_reset, ci_start, ci_done;
  logic [W-1:0] ci_dataa, ci_datab, ci_result;

  logic slave_dead, force_done;
  logic [W-1:0] sa, sb, s_res;
  logic s_run, s_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cnt = 0;
  int rst_cnt = 0;
  int e0, lat;

  always #5 clk = ~clk;

  ci_initiator #(
    .DATA_W(W),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_timeout(rsp_timeout),
    .busy       (busy),
    .ci_clk_en  (ci_clk_en),
    .ci_reset   (ci_reset),
    .ci_start   (ci_start),
    .ci_dataa   (ci_dataa),
    .ci_datab   (ci_datab),
    .ci_done    (ci_done),
    .ci_result  (ci_result)
  );

  // Euclid GCD slave: one modulo step per enabled cycle.
  always @(posedge clk) begin
    if (ci_reset) begin
      s_run  <= 1'b0;
      s_done <= 1'b0;
      s_res  <= '0;
      sa     <= '0;
      sb     <= '0;
    end else if (ci_clk_en) begin
      s_done <= 1'b0;
      if (ci_start) begin
        sa    <= ci_dataa;
        sb    <= ci_datab;
        s_run <= 1'b1;
      end else if (s_run) begin
        if (sb == 0) begin
          s_done <= 1'b1;
          s_res  <= sa;
          s_run  <= 1'b0;
        end else begin
          sa <= sb;
          sb <= sa % sb;
        end
      end
    end
  end

  assign ci_done   = (s_done & ~slave_dead) | force_done;
  assign ci_result = s_res;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ci_start) start_cnt <= start_cnt + 1;
    if (ci_reset) rst_cnt <= rst_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] a,
                      input logic [W-1:0] b);
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    step(1);
    e0        = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    while (!rsp_valid && (cyc - e0) < 100)
      step(1);
    lat = cyc - e0;
  endtask

  initial begin
    reset      = 1'b1;
    hold       = 1'b0;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b1;
    slave_dead = 1'b0;
    force_done = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);

    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_ci_start", ci_start, 0);
    check("rst_dataa", ci_dataa, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_ci_reset", ci_reset, 0);

    // (7,0): immediate finish
    start_cnt = 0;
    send(7, 0);
    check("s70_start", ci_start, 1);
    check("s70_dataa", ci_dataa, 7);
    check("s70_busy", busy, 1);
    wait_rsp();
    check("s70_lat", lat, 3);
    check("s70_res", rsp_result, 7);
    check("s70_to", rsp_timeout, 0);
    check("s70_starts", start_cnt, 1);
    step(1);
    check("s70_idle", req_ready, 1);

    // (48,18) -> 6
    start_cnt = 0;
    send(48, 18);
    wait_rsp();
    check("g48_lat", lat, 6);
    check("g48_res", rsp_result, 6);
    check("g48_to", rsp_timeout, 0);
    check("g48_starts", start_cnt, 1);
    step(1);

    // (100,75) with 5 held WAIT cycles -> 25
    send(100, 75);
    step(1);
    hold = 1'b1;
    #1;
    check("h_clk_en", ci_clk_en, 0);
    step(5);
    hold = 1'b0;
    wait_rsp();
    check("h_lat", lat, 10);
    check("h_res", rsp_result, 25);
    check("h_to", rsp_timeout, 0);
    step(1);

    // Dead slave: abort after 8 enabled WAIT cycles
    slave_dead = 1'b1;
    send(5, 3);
    rst_cnt = 0;
    wait_rsp();
    check("to_lat", lat, 10);
    check("to_rst_pulses", rst_cnt, 1);
    check("to_flag", rsp_timeout, 1);
    check("to_res", rsp_result, 0);
    check("to_ci_reset", ci_reset, 0);
    step(1);
    slave_dead = 1'b0;

    // Backpressure on (12,8) -> 4
    rsp_ready = 1'b0;
    send(12, 8);
    wait_rsp();
    check("bp_lat", lat, 5);
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("bp_valid", rsp_valid, 1);
      check("bp_res", rsp_result, 4);
      check("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    step(1);
    check("bp_next_ready", req_ready, 1);
    check("bp_valid_drop", rsp_valid, 0);

    // Reset in WAIT, then spurious done in IDLE
    send(48, 18);
    step(2);
    reset = 1'b1;
    #1;
    check("mr_ci_reset", ci_reset, 1);
    step(1);
    reset = 1'b0;
    check("mr_busy", busy, 0);
    check("mr_valid", rsp_valid, 0);
    force_done = 1'b1;
    step(1);
    force_done = 1'b0;
    step(3);
    check("sp_valid", rsp_valid, 0);
    check("sp_busy", busy, 0);
    check("sp_ready", req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
